// File: rtl/fmap_pkg.sv
// Shared defaults and FSM state encoding for the feature-map stream transmitter.
package fmap_pkg;

    localparam int unsigned FMAP_DATA_WIDTH = 24;
    localparam int unsigned FMAP_IMG_W      = 28;
    localparam int unsigned FMAP_IMG_H      = 28;
    localparam int unsigned FMAP_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush,
        StDone
    } fmap_state_e;

endpackage

// File: rtl/fmap_ram.sv
// Frame memory: one write port, one read port, registered read data.
// The array itself is never reset; only the read register is.
module fmap_ram #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

    // Array write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read data only changes on a read, so the output holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem[raddr_i];
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_stream_tx.sv
// Streams a stored feature map in raster order, one pixel per unpaused cycle,
// with row/frame markers aligned to the registered read data.
module fmap_stream_tx
    import fmap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FMAP_DATA_WIDTH,
    parameter int unsigned IMG_W      = FMAP_IMG_W,
    parameter int unsigned IMG_H      = FMAP_IMG_H,
    parameter int unsigned ADDR_WIDTH = FMAP_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  pause,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  row_last,
    output logic                  frame_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_WIDTH:0]   FRAME_PIX = (ADDR_WIDTH + 1)'(IMG_W * IMG_H);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMG_H - 1);

    fmap_state_e           state_d, state_q;
    logic [ADDR_WIDTH-1:0] ptr_d, ptr_q;
    logic [COL_W-1:0]      col_d, col_q;
    logic [ROW_W-1:0]      row_d, row_q;
    logic                  valid_d, valid_q;
    logic                  row_last_d, row_last_q;
    logic                  frame_last_d, frame_last_q;
    logic                  done_d, done_q;
    logic                  rd_en;
    logic                  mem_we;

    // Writes land only while idle and inside the frame.
    assign mem_we = wr_en && (state_q == StIdle) && ({1'b0, wr_addr} < FRAME_PIX);

    fmap_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (rd_en),
        .raddr_i (ptr_q),
        .rdata_o (data_out)
    );

    // Next-state, read issue and marker pipeline inputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        col_d   = col_q;
        row_d   = row_q;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StStream;
                    ptr_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StStream: begin
                if (!pause) begin
                    rd_en = 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        state_d = StFlush;
                    end else begin
                        ptr_d = ptr_q + ADDR_WIDTH'(1);
                    end
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        valid_d      = rd_en;
        row_last_d   = rd_en && (col_q == LAST_COL);
        frame_last_d = rd_en && (ptr_q == LAST_ADDR);
        done_d       = (state_q == StDone);
    end

    // State, counters and output pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            valid_q      <= 1'b0;
            row_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            valid_q      <= valid_d;
            row_last_q   <= row_last_d;
            frame_last_q <= frame_last_d;
            done_q       <= done_d;
        end
    end

    assign valid_out  = valid_q;
    assign row_last   = row_last_q;
    assign frame_last = frame_last_q;
    assign busy       = (state_q == StStream) || (state_q == StFlush);
    assign done       = done_q;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Bench for fmap_stream_tx on a 4x3 frame with mem[a] = 3*a.
// Cycle n is the interval ending at clock edge n; start sampled at edge k.
module tb_fmap_stream_tx;

    localparam int DW = 24;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          pause;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          row_last;
    logic          frame_last;
    logic          busy;
    logic          done;

    fmap_stream_tx #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .pause      (pause),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .row_last   (row_last),
        .frame_last (frame_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // cyc equals the current cycle index between edges
    int cyc = 1;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          rl;
        logic          fl;
        int            cyc;
    } exp_t;

    typedef struct {
        int            pstart;
        int            plen;
        bit            restart;
        bit            midwr;
        bit            wr55;
        int            done_off;
        logic [DW-1:0] first;
    } vec_t;

    exp_t          q[$];
    exp_t          e;
    logic [DW-1:0] mem_m [N];
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] first_seen = '0;
    bit            first_pending = 1'b0;
    bit            mon_en = 1'b0;
    int            exp_done = -1;
    int            busy_lo = 1;
    int            busy_hi = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    vec_t          tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: pop one expected pixel per valid cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_out) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", valid_out, 1'b0);
                end else begin
                    e = q.pop_front();
                    check("data", data_out, e.data);
                    check("row_last", row_last, e.rl);
                    check("frame_last", frame_last, e.fl);
                    check("valid_cycle", cyc, e.cyc);
                    last_data = e.data;
                    if (first_pending) begin
                        first_seen    = data_out;
                        first_pending = 1'b0;
                    end
                end
            end else begin
                check("idle_flags", {row_last, frame_last}, 2'b00);
                check("data_hold", data_out, last_data);
            end
            check("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
            if (done || cyc == exp_done) begin
                check("done", done, cyc == exp_done);
            end
        end
    end

    task automatic write_word(input int a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        if (a < N) mem_m[a] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic push_frame(input int k, input int pstart, input int plen, output int c);
        c = k + 1;
        for (int i = 0; i < N; i++) begin
            while (c >= k + pstart && c < k + pstart + plen) c++;
            q.push_back('{data: mem_m[i], rl: (i % W == W - 1), fl: (i == N - 1), cyc: c + 1});
            c++;
        end
    endtask

    task automatic run_frame(input vec_t v);
        int k;
        int c;
        @(posedge clk); #1;
        k     = cyc;
        start = 1'b1;
        if (v.wr55) begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_data  = 24'h000055;
            mem_m[0] = 24'h000055;
        end
        push_frame(k, v.pstart, v.plen, c);
        busy_lo       = k + 1;
        busy_hi       = c;
        exp_done      = k + v.done_off;
        first_pending = 1'b1;
        do begin
            @(posedge clk); #1;
            pause   = (cyc >= k + v.pstart) && (cyc < k + v.pstart + v.plen);
            start   = v.restart && (cyc == k + 5);
            wr_en   = v.midwr && (cyc == k + 6);
            wr_addr = '0;
            wr_data = 24'hABCDEF;
        end while (cyc < exp_done + 1);
        pause = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        check("queue_drained", q.size(), 0);
        check("first_data", first_seen, v.first);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int c;

        tbl[0] = '{pstart: 0, plen: 0, restart: 0, midwr: 0, wr55: 0, done_off: 15, first: 24'h0};
        tbl[1] = '{pstart: 4, plen: 3, restart: 0, midwr: 0, wr55: 0, done_off: 18, first: 24'h0};
        tbl[2] = '{pstart: 0, plen: 0, restart: 1, midwr: 1, wr55: 0, done_off: 15, first: 24'h0};
        tbl[3] = '{pstart: 0, plen: 0, restart: 0, midwr: 0, wr55: 0, done_off: 15, first: 24'h0};
        tbl[4] = '{pstart: 0, plen: 0, restart: 0, midwr: 0, wr55: 1, done_off: 15,
                   first: 24'h000055};

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        pause   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", data_out, 0);
        check("reset_valid", valid_out, 0);
        check("reset_row_last", row_last, 0);
        check("reset_frame_last", frame_last, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int a = 0; a < N; a++) write_word(a, DW'(3 * a));
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        // Restore pixel 0, then an out-of-frame write that must be dropped.
        write_word(0, 24'h0);
        write_word(N, 24'h777777);

        // Abort a frame with an asynchronous reset in cycle k+7.
        @(posedge clk); #1;
        k     = cyc;
        start = 1'b1;
        push_frame(k, 0, 0, c);
        busy_lo       = k + 1;
        busy_hi       = c;
        exp_done      = k + 15;
        first_pending = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_data", data_out, 0);
        check("abort_valid", valid_out, 0);
        check("abort_row_last", row_last, 0);
        check("abort_frame_last", frame_last, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_first_data", first_seen, 24'h0);
        q.delete();
        exp_done  = -1;
        busy_hi   = 0;
        last_data = '0;
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);

        run_frame(tbl[0]);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
